player_motion_controller: RTL and testbench

PLAYER_MOTION_CONTROLLER -- requirements
Module: player_motion_controller

---
 rtl/player_motion_controller_if.sv | 22 ++
 rtl/player_motion_controller.sv | 172 +++++++++++++++++
 tb/tb_player_motion_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_controller_if.sv
// Frame-sync, key and collision inputs plus scroll/animation outputs of the motion controller.
// master drives the inputs, slave is the controller side.
interface player_motion_controller_if;
  logic        VS;
  logic [7:0]  keycode;
  logic        Blocked;
  logic        Character_Moving;
  logic [1:0]  Direction;
  logic [10:0] topleftX;
  logic [10:0] topleftY;
  logic        Step_Done;

  modport master (
    output VS, keycode, Blocked,
    input  Character_Moving, Direction, topleftX, topleftY, Step_Done
  );

  modport slave (
    input  VS, keycode, Blocked,
    output Character_Moving, Direction, topleftX, topleftY, Step_Done
  );
endinterface

// File: rtl/player_motion_controller.sv
// Tile-stepped map scrolling: turn in place or walk one tile per key, advancing only on VS frame ticks.
// Outputs are registered; state moves one tick after the VS rising edge is seen.
module player_motion_controller #(
  parameter int STEP_PIX       = 16,
  parameter int FRAMES_PER_PIX = 2,
  parameter int TURN_FRAMES    = 4,
  parameter int MAX_X          = 384,
  parameter int MAX_Y          = 544,
  parameter int START_X        = 300,
  parameter int START_Y        = 300
) (
  input logic                        Clk,
  input logic                        Reset,
  player_motion_controller_if.slave  bus
);

  localparam int PIX_W  = $clog2(STEP_PIX + 1);
  localparam int SUB_W  = $clog2(FRAMES_PER_PIX + 1);
  localparam int TURN_W = $clog2(TURN_FRAMES + 1);

  localparam logic [PIX_W-1:0]  L_PIX_LAST  = PIX_W'(STEP_PIX - 1);
  localparam logic [SUB_W-1:0]  L_SUB_LAST  = SUB_W'(FRAMES_PER_PIX - 1);
  localparam logic [TURN_W-1:0] L_TURN_LAST = TURN_W'(TURN_FRAMES - 1);
  localparam logic [10:0]       L_MAX_X     = 11'(MAX_X);
  localparam logic [10:0]       L_MAX_Y     = 11'(MAX_Y);
  localparam logic [10:0]       L_START_X   = 11'(START_X);
  localparam logic [10:0]       L_START_Y   = 11'(START_Y);

  typedef enum logic [1:0] {IDLE, TURN, WALK} state_t;

  state_t            r_state;
  logic              r_vs_q;
  logic [1:0]        r_dir;
  logic              r_moving;
  logic              r_done;
  logic [10:0]       r_x;
  logic [10:0]       r_y;
  logic [TURN_W-1:0] r_turn_cnt;
  logic [SUB_W-1:0]  r_sub_cnt;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic              r_blocked;

  logic              w_tick;
  logic              w_key_vld;
  logic [1:0]        w_key_dir;
  logic              w_pix_edge;
  logic              w_step_end;
  logic              w_move;
  logic [10:0]       w_x_nxt;
  logic [10:0]       w_y_nxt;
  logic              w_blk_nxt;

  // True when the view already touches the map border in direction d.
  function automatic logic at_edge(input logic [1:0] d, input logic [10:0] x, input logic [10:0] y);
    case (d)
      2'd0:    at_edge = (y == 11'd0);
      2'd1:    at_edge = (x == L_MAX_X);
      2'd2:    at_edge = (y == L_MAX_Y);
      default: at_edge = (x == 11'd0);
    endcase
  endfunction

  assign w_tick = bus.VS & ~r_vs_q;

  always_comb begin
    w_key_vld = 1'b1;
    w_key_dir = 2'd0;
    case (bus.keycode)
      8'h1A:   w_key_dir = 2'd0;
      8'h07:   w_key_dir = 2'd1;
      8'h16:   w_key_dir = 2'd2;
      8'h04:   w_key_dir = 2'd3;
      default: w_key_vld = 1'b0;
    endcase
  end

  assign w_pix_edge = (r_sub_cnt == L_SUB_LAST);
  assign w_step_end = w_pix_edge && (r_pix_cnt == L_PIX_LAST);
  // Per-pixel border test keeps a partial final step from overshooting the map.
  assign w_move     = (r_state == WALK) && w_tick && w_pix_edge && !r_blocked && !at_edge(r_dir, r_x, r_y);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_move) begin
      case (r_dir)
        2'd0:    w_y_nxt = r_y - 11'd1;
        2'd1:    w_x_nxt = r_x + 11'd1;
        2'd2:    w_y_nxt = r_y + 11'd1;
        default: w_x_nxt = r_x - 11'd1;
      endcase
    end
  end

  // Re-latch on a chained step must see the position after this tick's final pixel.
  assign w_blk_nxt = bus.Blocked | at_edge(r_dir, w_x_nxt, w_y_nxt);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_vs_q     <= 1'b0;
      r_dir      <= 2'd0;
      r_moving   <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= L_START_X;
      r_y        <= L_START_Y;
      r_turn_cnt <= '0;
      r_sub_cnt  <= '0;
      r_pix_cnt  <= '0;
      r_blocked  <= 1'b0;
    end else begin
      r_vs_q <= bus.VS;
      r_done <= 1'b0;
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_key_vld) begin
              r_moving <= 1'b0;
            end else if (w_key_dir != r_dir) begin
              r_dir      <= w_key_dir;
              r_turn_cnt <= '0;
              r_state    <= TURN;
            end else begin
              r_state   <= WALK;
              r_moving  <= 1'b1;
              r_pix_cnt <= '0;
              r_sub_cnt <= '0;
              r_blocked <= w_blk_nxt;
            end
          end
          TURN: begin
            if (r_turn_cnt == L_TURN_LAST) begin
              r_turn_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_turn_cnt <= r_turn_cnt + 1'b1;
            end
          end
          WALK: begin
            if (w_pix_edge) begin
              r_sub_cnt <= '0;
              if (w_step_end) begin
                r_done    <= 1'b1;
                r_pix_cnt <= '0;
                if (w_key_vld && (w_key_dir == r_dir)) begin
                  r_blocked <= w_blk_nxt;
                end else begin
                  r_state  <= IDLE;
                  r_moving <= 1'b0;
                end
              end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
              end
            end else begin
              r_sub_cnt <= r_sub_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Character_Moving = r_moving;
  assign bus.Direction        = r_dir;
  assign bus.topleftX         = r_x;
  assign bus.topleftY         = r_y;
  assign bus.Step_Done        = r_done;

endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: vector table, directed corner sequences and random keys
// checked against a per-tick step model working from elapsed-tick arithmetic.
module tb_player_motion_controller;

  localparam int STEP  = 16;
  localparam int FPP   = 2;
  localparam int TURNF = 4;
  localparam int MAXX  = 384;
  localparam int MAXY  = 544;
  localparam int SX    = 300;
  localparam int SY    = 300;

  logic Clk;
  logic Reset;
  player_motion_controller_if bus();

  player_motion_controller dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: mode 0 idle, 1 turning, 2 walking
  int m_mode, m_dir, m_x, m_y, m_moving, m_done, m_tcnt, m_k, m_sx, m_sy, m_sblk;
  // DUT outputs captured right after each tick
  int g_mov, g_dir, g_x, g_y, g_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int kdir(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h07:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_dir = 0; m_x = SX; m_y = SY; m_moving = 0; m_done = 0;
    m_tcnt = 0; m_k = 0; m_sx = SX; m_sy = SY; m_sblk = 0;
  endtask

  task automatic model_start(input logic blk);
    int at;
    at = (m_dir == 0 && m_y == 0) || (m_dir == 1 && m_x == MAXX) ||
         (m_dir == 2 && m_y == MAXY) || (m_dir == 3 && m_x == 0);
    m_mode = 2; m_moving = 1; m_k = 0; m_sx = m_x; m_sy = m_y;
    m_sblk = (blk || at) ? 1 : 0;
  endtask

  task automatic model_tick(input logic [7:0] key, input logic blk);
    int kd, d;
    kd = kdir(key);
    m_done = 0;
    case (m_mode)
      0: begin
        if (kd < 0) m_moving = 0;
        else if (kd != m_dir) begin m_dir = kd; m_mode = 1; m_tcnt = 0; end
        else model_start(blk);
      end
      1: begin
        m_tcnt++;
        if (m_tcnt == TURNF) m_mode = 0;
      end
      default: begin
        m_k++;
        if (m_sblk == 0) begin
          d = m_k / FPP;
          case (m_dir)
            0: m_y = clampi(m_sy - d, MAXY);
            1: m_x = clampi(m_sx + d, MAXX);
            2: m_y = clampi(m_sy + d, MAXY);
            default: m_x = clampi(m_sx - d, MAXX);
          endcase
        end
        if (m_k == STEP * FPP) begin
          m_done = 1;
          if (kd == m_dir) model_start(blk);
          else begin m_mode = 0; m_moving = 0; end
        end
      end
    endcase
  endtask

  task automatic do_tick(input logic [7:0] key, input logic blk);
    @(negedge Clk);
    bus.keycode = key;
    bus.Blocked = blk;
    bus.VS      = 1'b1;
    @(negedge Clk);
    bus.VS = 1'b0;
    model_tick(key, blk);
    g_mov = int'(bus.Character_Moving); g_dir = int'(bus.Direction);
    g_x = int'(bus.topleftX); g_y = int'(bus.topleftY); g_done = int'(bus.Step_Done);
    chk("moving", g_mov, m_moving);
    chk("direction", g_dir, m_dir);
    chk("topleftX", g_x, m_x);
    chk("topleftY", g_y, m_y);
    chk("step_done", g_done, m_done);
    @(negedge Clk);
    chk("step_done_width", int'(bus.Step_Done), 0);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; bus.VS = 1'b0; bus.keycode = 8'h00; bus.Blocked = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] key;
    logic       blk;
    int         mov;
    int         dir;
    int         x;
    int         y;
    int         done;
  } vec_t;

  vec_t vt[11];

  initial begin
    int dones, low_seen, cur_key;
    vt[0]  = '{8'h00, 1'b0, 0, 0, 300, 300, 0};
    vt[1]  = '{8'h07, 1'b0, 0, 1, 300, 300, 0};
    vt[2]  = '{8'h16, 1'b0, 0, 1, 300, 300, 0};
    vt[3]  = '{8'h16, 1'b1, 0, 1, 300, 300, 0};
    vt[4]  = '{8'h07, 1'b0, 0, 1, 300, 300, 0};
    vt[5]  = '{8'h07, 1'b0, 0, 1, 300, 300, 0};
    vt[6]  = '{8'h07, 1'b0, 1, 1, 300, 300, 0};
    vt[7]  = '{8'h07, 1'b1, 1, 1, 300, 300, 0};
    vt[8]  = '{8'h16, 1'b0, 1, 1, 301, 300, 0};
    vt[9]  = '{8'h00, 1'b0, 1, 1, 301, 300, 0};
    vt[10] = '{8'h00, 1'b0, 1, 1, 302, 300, 0};

    Reset = 1'b1; bus.VS = 1'b0; bus.keycode = 8'h00; bus.Blocked = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    chk("rst_moving", int'(bus.Character_Moving), 0);
    chk("rst_dir", int'(bus.Direction), 0);
    chk("rst_x", int'(bus.topleftX), SX);
    chk("rst_y", int'(bus.topleftY), SY);
    chk("rst_done", int'(bus.Step_Done), 0);
    Reset = 1'b0;

    // turn right then walk; key changes during turn and walk are ignored
    for (int i = 0; i < 11; i++) begin
      do_tick(vt[i].key, vt[i].blk);
      chk($sformatf("vec%0d_mov", i), g_mov, vt[i].mov);
      chk($sformatf("vec%0d_dir", i), g_dir, vt[i].dir);
      chk($sformatf("vec%0d_x", i), g_x, vt[i].x);
      chk($sformatf("vec%0d_y", i), g_y, vt[i].y);
      chk($sformatf("vec%0d_done", i), g_done, vt[i].done);
    end
    dones = 0;
    for (int i = 0; i < 28; i++) begin
      do_tick(8'h00, 1'b0);
      dones += g_done;
    end
    chk("right_step_x", g_x, 316);
    chk("right_step_done", dones, 1);
    chk("right_step_idle", g_mov, 0);

    // up held for three chained steps
    apply_reset();
    dones = 0; low_seen = 0;
    for (int i = 0; i < 1 + 3 * STEP * FPP; i++) begin
      do_tick(8'h1A, 1'b0);
      dones += g_done;
      if (g_mov == 0) low_seen++;
      if (i == STEP * FPP) chk("up_one_step_y", g_y, 284);
      if (i == STEP * FPP) chk("up_one_step_x", g_x, 300);
      if (g_done == 1) chk("done_spacing", (i % (STEP * FPP)), 0);
    end
    chk("three_steps_y", g_y, 252);
    chk("three_steps_done", dones, 3);
    chk("three_steps_gap", low_seen, 0);

    // blocked at step start, released mid-step
    apply_reset();
    do_tick(8'h1A, 1'b1);
    for (int i = 0; i < STEP * FPP; i++) do_tick(8'h00, (i < 5) ? 1'b1 : 1'b0);
    chk("blocked_y", g_y, 300);
    chk("blocked_done", g_done, 1);

    // walk left into the x=0 border: partial step then a fully blocked step
    apply_reset();
    for (int i = 0; i < 6; i++) do_tick(8'h04, 1'b0);
    for (int s = 0; s < 20; s++) begin
      dones = 0; low_seen = 0;
      for (int i = 0; i < STEP * FPP; i++) begin
        do_tick(8'h04, 1'b0);
        dones += g_done;
        if (g_mov == 0) low_seen++;
      end
      if (s == 18) chk("left_partial_x", g_x, 0);
    end
    chk("left_edge_x", g_x, 0);
    chk("left_edge_dir", g_dir, 3);
    chk("left_edge_done", dones, 1);
    chk("left_edge_moving", low_seen, 0);

    // asynchronous reset ten ticks into a step
    apply_reset();
    for (int i = 0; i < 11; i++) do_tick(8'h1A, 1'b0);
    chk("pre_abort_y", g_y, 295);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort_moving", int'(bus.Character_Moving), 0);
    chk("abort_y", int'(bus.topleftY), SY);
    chk("abort_x", int'(bus.topleftX), SX);
    chk("abort_dir", int'(bus.Direction), 0);
    chk("abort_done", int'(bus.Step_Done), 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      do_tick(8'h00, 1'b0);
      dones += g_done;
    end
    chk("abort_no_done", dones, 0);

    // random keys and collisions against the model
    apply_reset();
    cur_key = 8'h1A;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0: cur_key = 8'h1A;
          1: cur_key = 8'h07;
          2: cur_key = 8'h16;
          3: cur_key = 8'h04;
          4: cur_key = 8'h00;
          default: cur_key = 8'h55;
        endcase
      end
      do_tick(8'(cur_key), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
